// File: rtl/cvxif_result_collector.sv
// Coprocessor result collector: ID scoreboard, result FIFO and a single register-file writeback port.
// Optional ID checking is enabled by defining CVXIF_RESULT_ID_CHECK_EN.
module cvxif_result_collector #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IdWidth = 3,
  parameter int unsigned Depth   = 4,
  localparam int unsigned NrIds  = 2**IdWidth,
  localparam int unsigned CntW   = $clog2(Depth) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic               result_valid_i,
  output logic               result_ready_o,
  input  logic [IdWidth-1:0] result_id_i,
  input  logic [4:0]         result_rd_i,
  input  logic [XLEN-1:0]    result_data_i,
  input  logic               result_we_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [4:0]         wb_rd_o,
  output logic [XLEN-1:0]    wb_data_o,
  output logic [IdWidth-1:0] wb_id_o,
  output logic [NrIds-1:0]   outstanding_o,
  output logic [CntW-1:0]    count_o,
  output logic               err_o,
  output logic [1:0]         err_code_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [4:0]         rd_q   [Depth];
  logic [XLEN-1:0]    data_q [Depth];
  logic [IdWidth-1:0] id_q   [Depth];

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, accept, expected, push, pop;

  // No bypass: a full FIFO refuses even if the head drains this cycle.
  assign full           = (count_q == CntW'(Depth));
  assign result_ready_o = !full;
  assign accept         = result_valid_i && !full;
  assign push           = accept && expected && result_we_i && (result_rd_i != 5'd0);
  assign wb_valid_o     = (count_q != '0);
  assign pop            = wb_valid_o && wb_ready_i;
  assign count_o        = count_q;

  // Payload is zeroed when empty so stale entries never leak out.
  assign wb_rd_o   = wb_valid_o ? rd_q[rptr_q]   : '0;
  assign wb_data_o = wb_valid_o ? data_q[rptr_q] : '0;
  assign wb_id_o   = wb_valid_o ? id_q[rptr_q]   : '0;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_q[wptr_q]   <= result_rd_i;
      data_q[wptr_q] <= result_data_i;
      id_q[wptr_q]   <= result_id_i;
    end
  end

`ifdef CVXIF_RESULT_ID_CHECK_EN
  logic [NrIds-1:0] outstanding_q, outstanding_d;
  logic [1:0]       err_code_q, err_code_d;

  assign expected = outstanding_q[result_id_i];

  // Retire before issue, so a same-ID issue+result leaves the bit set without error.
  always_comb begin
    outstanding_d = outstanding_q;
    err_code_d    = 2'b00;
    if (accept) begin
      if (expected) outstanding_d[result_id_i] = 1'b0;
      else          err_code_d[0] = 1'b1;
    end
    if (issue_valid_i) begin
      if (outstanding_d[issue_id_i]) err_code_d[1] = 1'b1;
      outstanding_d[issue_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      err_code_q    <= 2'b00;
    end else begin
      outstanding_q <= outstanding_d;
      err_code_q    <= err_code_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign err_code_o    = err_code_q;
  assign err_o         = |err_code_q;
`else
  logic unused_issue;

  assign unused_issue  = ^{issue_valid_i, issue_id_i};
  assign expected      = 1'b1;
  assign outstanding_o = '0;
  assign err_code_o    = 2'b00;
  assign err_o         = 1'b0;
`endif

endmodule
